mio_bus_responder: RTL and testbench

Memory/IO bus responder that answers the pipelined CPU's data-side requests (address, write data, write strobe, DMType) and returns read data with a mio_ready handshake. It decodes each request to synchronous data RAM or a peripheral register port, generates byte-lane enables, and sign- or zero-extends read data per DMType. It sits between the CPU core's memory stage and the RAM/peripheral fabric.

---
 rtl/mio_bus_responder_if.sv | 21 ++
 rtl/mio_bus_responder.sv | 218 +++++++++++++++++++++
 tb/tb_mio_bus_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_bus_responder_if.sv
// CPU data-side request/response bundle seen by mio_bus_responder.
interface mio_bus_responder_if;
    logic        cpu_mio;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [2:0]  cpu_dmtype;
    logic [31:0] cpu_rdata;
    logic        mio_ready;
    logic        bus_err;

    modport master (
        output cpu_mio, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
        input  cpu_rdata, mio_ready, bus_err
    );

    modport slave (
        input  cpu_mio, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
        output cpu_rdata, mio_ready, bus_err
    );
endinterface

// File: rtl/mio_bus_responder.sv
// Data-side memory/IO responder: routes CPU requests to sync RAM or a peripheral port.
// Optional macro MIO_MISALIGN_TRAP_EN: misaligned half/word accesses complete at once with bus_err.
module mio_bus_responder #(
    parameter int unsigned RAM_AW      = 10,
    parameter int unsigned RAM_WAIT    = 0,
    parameter int unsigned PER_TIMEOUT = 16,
    parameter logic [31:0] PERIPH_BASE = 32'hF000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    mio_bus_responder_if.slave    mio,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic                  per_en,
    output logic                  per_we,
    output logic [9:0]            per_addr,
    output logic [31:0]           per_wdata,
    input  logic [31:0]           per_rdata,
    input  logic                  per_ack
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_ACC,
        S_RAM_CAP,
        S_PER_ACC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [2:0]       dmt_q, dmt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wrep_q, wrep_d;
    logic [3:0]       lanes_q, lanes_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;
    logic             ram_en_q, ram_en_d;
    logic [3:0]       ram_we_q, ram_we_d;
    logic             per_en_q, per_en_d;
    logic             per_we_q, per_we_d;
    logic             misalign_c;
    logic             unused_addr_bits;

    // Byte enables for the addressed lane; low address bits beyond the access size are ignored.
    function automatic logic [3:0] lane_mask(input logic [2:0] dmt, input logic [1:0] a);
        case (dmt)
            3'd1, 3'd2: lane_mask = a[1] ? 4'b1100 : 4'b0011;
            3'd3, 3'd4: lane_mask = 4'b0001 << a;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] dmt, input logic [31:0] wd);
        case (dmt)
            3'd1, 3'd2: replicate = {2{wd[15:0]}};
            3'd3, 3'd4: replicate = {4{wd[7:0]}};
            default:    replicate = wd;
        endcase
    endfunction

    // Select the addressed lane and sign/zero extend it to 32 bits.
    function automatic logic [31:0] extend(input logic [2:0] dmt, input logic [1:0] a,
                                           input logic [31:0] d);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? d[31:16] : d[15:0];
        b = d[{a, 3'b000} +: 8];
        case (dmt)
            3'd1:    extend = {{16{h[15]}}, h};
            3'd2:    extend = {16'h0000, h};
            3'd3:    extend = {{24{b[7]}}, b};
            3'd4:    extend = {24'h00_0000, b};
            default: extend = d;
        endcase
    endfunction

`ifdef MIO_MISALIGN_TRAP_EN
    always_comb begin
        case (mio.cpu_dmtype)
            3'd1, 3'd2: misalign_c = mio.cpu_addr[0];
            3'd3, 3'd4: misalign_c = 1'b0;
            default:    misalign_c = (mio.cpu_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign misalign_c = 1'b0;
`endif

    // Next-state, request latch and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        dmt_d   = dmt_q;
        addr_d  = addr_q;
        wrep_d  = wrep_q;
        lanes_d = lanes_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (mio.cpu_mio) begin
                    we_d    = mio.cpu_we;
                    dmt_d   = mio.cpu_dmtype;
                    addr_d  = mio.cpu_addr;
                    wrep_d  = replicate(mio.cpu_dmtype, mio.cpu_wdata);
                    lanes_d = lane_mask(mio.cpu_dmtype, mio.cpu_addr[1:0]);
                    cnt_d   = '0;
                    if (misalign_c) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (mio.cpu_addr[31:28] == PERIPH_BASE[31:28]) begin
                        state_d = S_PER_ACC;
                    end else begin
                        state_d = S_RAM_ACC;
                    end
                end
            end
            S_RAM_ACC: begin
                if (cnt_q == CNT_W'(RAM_WAIT)) begin
                    cnt_d = '0;
                    if (we_q) begin
                        state_d = S_DONE;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_RAM_CAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RAM_CAP: begin
                rdata_d = extend(dmt_q, addr_q[1:0], ram_rdata);
                err_d   = 1'b0;
                state_d = S_DONE;
            end
            S_PER_ACC: begin
                if (per_ack) begin
                    if (!we_q) rdata_d = extend(dmt_q, addr_q[1:0], per_rdata);
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(PER_TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ram_en_d = (state_d == S_RAM_ACC);
        ram_we_d = (ram_en_d && we_d) ? lanes_d : 4'b0000;
        per_en_d = (state_d == S_PER_ACC);
        per_we_d = per_en_d && we_d;
        ready_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            dmt_q    <= '0;
            addr_q   <= '0;
            wrep_q   <= '0;
            lanes_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            ram_en_q <= 1'b0;
            ram_we_q <= '0;
            per_en_q <= 1'b0;
            per_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            dmt_q    <= dmt_d;
            addr_q   <= addr_d;
            wrep_q   <= wrep_d;
            lanes_q  <= lanes_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            ram_en_q <= ram_en_d;
            ram_we_q <= ram_we_d;
            per_en_q <= per_en_d;
            per_we_q <= per_we_d;
        end
    end

    // Upper address bits are latched but only partly decoded (RAM aliases).
    assign unused_addr_bits = ^addr_q;

    assign mio.cpu_rdata = rdata_q;
    assign mio.mio_ready = ready_q;
    assign mio.bus_err   = err_q;
    assign ram_en        = ram_en_q;
    assign ram_we        = ram_we_q;
    assign ram_addr      = addr_q[RAM_AW+1:2];
    assign ram_wdata     = wrep_q;
    assign per_en        = per_en_q;
    assign per_we        = per_we_q;
    assign per_addr      = addr_q[11:2];
    assign per_wdata     = wrep_q;
endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomized bench for mio_bus_responder with a transaction-level reference model.
module tb_mio_bus_responder;
    localparam int unsigned RAM_AW      = 10;
    localparam int unsigned RAM_WAIT    = 2;
    localparam int unsigned PER_TIMEOUT = 16;
    localparam int unsigned RAM_WORDS   = 1 << RAM_AW;
`ifdef MIO_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mio_bus_responder_if mio();
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              per_en;
    logic              per_we;
    logic [9:0]        per_addr;
    logic [31:0]       per_wdata;
    logic [31:0]       per_rdata;
    logic              per_ack;

    mio_bus_responder #(
        .RAM_AW(RAM_AW), .RAM_WAIT(RAM_WAIT), .PER_TIMEOUT(PER_TIMEOUT),
        .PERIPH_BASE(32'hF000_0000)
    ) dut (
        .clk(clk), .reset(reset), .mio(mio),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .per_en(per_en), .per_we(per_we), .per_addr(per_addr), .per_wdata(per_wdata),
        .per_rdata(per_rdata), .per_ack(per_ack)
    );

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        return w;
    endfunction

    // Synchronous RAM environment, read data one cycle after ram_en.
    logic [31:0] mem [0:RAM_WORDS-1];
    logic        mem_filled = 1'b0;
    always @(posedge clk) begin
        if (!mem_filled) begin
            for (int i = 0; i < RAM_WORDS; i++) mem[i] <= seed_word(i);
            mem_filled <= 1'b1;
        end else if (ram_en) begin
            mem[ram_addr] <= merge(mem[ram_addr], ram_we, ram_wdata);
            ram_rdata     <= mem[ram_addr];
        end
    end

    // Reference model: access size in bytes, aligned offset, lanes, replication, extension.
    function automatic int m_size(input logic [2:0] d);
        if (d == 3'd1 || d == 3'd2) return 2;
        if (d == 3'd3 || d == 3'd4) return 1;
        return 4;
    endfunction

    function automatic int m_off(input logic [2:0] d, input logic [1:0] a);
        return (int'(a) / m_size(d)) * m_size(d);
    endfunction

    function automatic logic [3:0] m_lanes(input logic [2:0] d, input logic [1:0] a);
        return 4'(((1 << m_size(d)) - 1) << m_off(d, a));
    endfunction

    function automatic logic [31:0] m_rep(input logic [2:0] d, input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % m_size(d)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ext(input logic [2:0] d, input logic [1:0] a,
                                          input logic [31:0] w);
        logic [63:0] v, mask;
        int n;
        n    = m_size(d);
        mask = (64'd1 << (8 * n)) - 64'd1;
        v    = (64'(w) >> (8 * m_off(d, a))) & mask;
        if ((d == 3'd1 || d == 3'd3) && v[8*n-1]) v = v | ~mask;
        return 32'(v);
    endfunction

    function automatic logic m_trap(input logic [2:0] d, input logic [1:0] a);
        return TRAP_EN && ((int'(a) % m_size(d)) != 0);
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    logic [31:0] ref_mem [0:RAM_WORDS-1];
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          r_lat, r_ram_cyc, r_per_cyc;
    logic [31:0] r_rdata, r_wd1;
    logic        r_err;
    logic [3:0]  r_we1;
    logic [9:0]  r_addr1, r_paddr1;
    int          tcount = 0;

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [2:0] dmt);
        mio.cpu_mio    = 1'b1;
        mio.cpu_we     = we;
        mio.cpu_addr   = addr;
        mio.cpu_wdata  = wd;
        mio.cpu_dmtype = dmt;
    endtask

    // Entered at a negedge in DONE (or idle after reset with gap>=1); checks every cycle to mio_ready.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] dmt, input int ack_at, input logic [31:0] pdata,
                       input int gap);
        bit trap, is_per, is_ram, e_ram_en, e_per_en, timeout;
        int n_acc, lat;
        logic [3:0] ln;
        logic [31:0] rp;
        int idx;
        tcount++;
        trap    = m_trap(dmt, addr[1:0]);
        is_per  = !trap && (addr[31:28] == 4'hF);
        is_ram  = !trap && !is_per;
        ln      = m_lanes(dmt, addr[1:0]);
        rp      = m_rep(dmt, wd);
        idx     = int'(addr[RAM_AW+1:2]);
        timeout = is_per && !(ack_at >= 1 && ack_at <= int'(PER_TIMEOUT));
        n_acc   = 0;
        if (trap) lat = 1;
        else if (is_per) begin
            n_acc = timeout ? int'(PER_TIMEOUT) : ack_at;
            lat   = n_acc + 1;
        end else begin
            n_acc = 1 + int'(RAM_WAIT);
            lat   = we ? n_acc + 1 : n_acc + 2;
        end

        if (trap || timeout) begin
            exp_rdata = '0;
            exp_err   = 1'b1;
        end else if (is_per) begin
            exp_err = 1'b0;
            if (!we) exp_rdata = m_ext(dmt, addr[1:0], pdata);
        end else begin
            exp_err = 1'b0;
            if (we) ref_mem[idx] = merge(ref_mem[idx], ln, rp);
            else    exp_rdata    = m_ext(dmt, addr[1:0], ref_mem[idx]);
        end

        if (gap == 0) drive_req(we, addr, wd, dmt);
        else          mio.cpu_mio = 1'b0;
        @(negedge clk);
        chk($sformatf("t%0d idle ready", tcount), 32'(mio.mio_ready), 32'd0);
        chk($sformatf("t%0d idle en", tcount), {30'd0, ram_en, per_en}, 32'd0);
        if (gap > 0) begin
            repeat (gap - 1) @(negedge clk);
            drive_req(we, addr, wd, dmt);
        end

        r_ram_cyc = 0;
        r_per_cyc = 0;
        r_lat     = 0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            e_ram_en = is_ram && (c <= n_acc);
            e_per_en = is_per && (c <= n_acc);
            if (ram_en) r_ram_cyc++;
            if (per_en) r_per_cyc++;
            if (mio.mio_ready && r_lat == 0) r_lat = c;
            chk($sformatf("t%0d c%0d ram_en", tcount, c), 32'(ram_en), 32'(e_ram_en));
            chk($sformatf("t%0d c%0d ram_we", tcount, c), 32'(ram_we),
                32'((e_ram_en && we) ? ln : 4'b0000));
            chk($sformatf("t%0d c%0d per_en", tcount, c), 32'(per_en), 32'(e_per_en));
            chk($sformatf("t%0d c%0d mio_ready", tcount, c), 32'(mio.mio_ready), 32'(c == lat));
            if (e_ram_en) begin
                chk($sformatf("t%0d c%0d ram_addr", tcount, c), 32'(ram_addr), 32'(idx));
                chk($sformatf("t%0d c%0d ram_wdata", tcount, c), ram_wdata, rp);
            end
            if (e_per_en) begin
                chk($sformatf("t%0d c%0d per_addr", tcount, c), 32'(per_addr), 32'(addr[11:2]));
                chk($sformatf("t%0d c%0d per_we", tcount, c), 32'(per_we), 32'(we));
                chk($sformatf("t%0d c%0d per_wdata", tcount, c), per_wdata, rp);
            end
            if (c == 1) begin
                r_we1    = ram_we;
                r_addr1  = ram_addr;
                r_wd1    = ram_wdata;
                r_paddr1 = per_addr;
            end
            if (c == lat) begin
                r_rdata = mio.cpu_rdata;
                r_err   = mio.bus_err;
                chk($sformatf("t%0d cpu_rdata", tcount), mio.cpu_rdata, exp_rdata);
                chk($sformatf("t%0d bus_err", tcount), 32'(mio.bus_err), 32'(exp_err));
            end
            if (is_per) begin
                per_ack   = (c == ack_at);
                per_rdata = (c == ack_at) ? pdata : $urandom;
            end else begin
                per_ack   = 1'($urandom_range(0, 1));
                per_rdata = $urandom;
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int sel, r, ack;
        reset          = 1'b1;
        mio.cpu_mio    = 1'b0;
        mio.cpu_we     = 1'b0;
        mio.cpu_addr   = '0;
        mio.cpu_wdata  = '0;
        mio.cpu_dmtype = '0;
        per_ack        = 1'b0;
        per_rdata      = '0;
        for (int i = 0; i < int'(RAM_WORDS); i++) ref_mem[i] = seed_word(i);
        exp_rdata = '0;
        exp_err   = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst cpu_rdata", mio.cpu_rdata, 32'd0);
        chk("rst ready_err", {30'd0, mio.mio_ready, mio.bus_err}, 32'd0);
        chk("rst ram", {27'd0, ram_en, ram_we}, 32'd0);
        chk("rst ram_addr", 32'(ram_addr), 32'd0);
        chk("rst per", {30'd0, per_en, per_we}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Byte store: lane 3, word 4, replicated data.
        txn(1'b1, 32'h0000_0013, 32'h0000_00A5, 3'd3, 0, 0, 1);
        chk("sb ram_we", 32'(r_we1), 32'h8);
        chk("sb ram_addr", 32'(r_addr1), 32'd4);
        chk("sb ram_wdata", r_wd1, 32'hA5A5_A5A5);
        chk("sb latency", 32'(r_lat), 32'd4);
        txn(1'b1, 32'h0000_0010, 32'h8034_5678, 3'd0, 0, 0, 0);
        txn(1'b0, 32'h0000_0013, 32'h0, 3'd3, 0, 0, 0);
        chk("lb data", r_rdata, 32'hFFFF_FF80);
        chk("lb latency", 32'(r_lat), 32'd5);
        chk("lb ram_en cycles", 32'(r_ram_cyc), 32'd3);
        txn(1'b0, 32'h0000_0013, 32'h0, 3'd4, 0, 0, 2);
        chk("lbu data", r_rdata, 32'h0000_0080);
        txn(1'b0, 32'h0000_0012, 32'h0, 3'd1, 0, 0, 0);
        chk("lh data", r_rdata, 32'hFFFF_8034);
        txn(1'b0, 32'h0000_0010, 32'h0, 3'd2, 0, 0, 0);
        chk("lhu data", r_rdata, 32'h0000_5678);
        txn(1'b0, 32'h0000_1010, 32'h0, 3'd0, 0, 0, 0);
        chk("alias lw data", r_rdata, 32'h8034_5678);

        // Peripheral read acked on the third access cycle.
        txn(1'b0, 32'hF000_0010, 32'h0, 3'd0, 3, 32'h0000_1234, 1);
        chk("per lw data", r_rdata, 32'h0000_1234);
        chk("per lw per_addr", 32'(r_paddr1), 32'd4);
        chk("per lw per_en cycles", 32'(r_per_cyc), 32'd3);
        chk("per lw latency", 32'(r_lat), 32'd4);
        chk("per lw bus_err", 32'(r_err), 32'd0);
        // Peripheral write never acked: timeout.
        txn(1'b1, 32'hF000_0020, 32'h0000_0055, 3'd0, 0, 32'h0, 0);
        chk("per to per_en cycles", 32'(r_per_cyc), 32'd16);
        chk("per to latency", 32'(r_lat), 32'd17);
        chk("per to bus_err", 32'(r_err), 32'd1);
        chk("per to cpu_rdata", r_rdata, 32'd0);
        txn(1'b0, 32'h0000_0010, 32'h0, 3'd0, 0, 0, 0);
        chk("err clear", 32'(r_err), 32'd0);
        chk("err clear data", r_rdata, 32'h8034_5678);
        // Ack on the last allowed cycle still completes without error.
        txn(1'b0, 32'hF000_0004, 32'h0, 3'd0, 16, 32'hCAFE_0001, 0);
        chk("per late ack data", r_rdata, 32'hCAFE_0001);
        chk("per late ack err", 32'(r_err), 32'd0);

        // Misaligned word store.
        txn(1'b1, 32'h0000_0002, 32'h1122_3344, 3'd0, 0, 0, 0);
        if (TRAP_EN) begin
            chk("mis latency", 32'(r_lat), 32'd1);
            chk("mis bus_err", 32'(r_err), 32'd1);
            chk("mis ram_en cycles", 32'(r_ram_cyc), 32'd0);
        end else begin
            chk("mis ram_we", 32'(r_we1), 32'hF);
            chk("mis ram_addr", 32'(r_addr1), 32'd0);
            chk("mis bus_err", 32'(r_err), 32'd0);
        end

        // Reset asserted during the second RAM access cycle of a store.
        mio.cpu_mio = 1'b0;
        @(negedge clk);
        drive_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 3'd0);
        @(negedge clk);
        chk("rst-mid c1 ram_en", 32'(ram_en), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst-mid ram_en", 32'(ram_en), 32'd0);
        chk("rst-mid ram_we", 32'(ram_we), 32'd0);
        mio.cpu_mio = 1'b0;
        ref_mem[16] = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst-mid held", {30'd0, mio.mio_ready, ram_en}, 32'd0);
        end
        reset = 1'b0;
        exp_rdata = '0;
        exp_err   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst-mid after", {29'd0, mio.mio_ready, ram_en, per_en}, 32'd0);
        end
        chk("rst-mid cpu_rdata", mio.cpu_rdata, 32'd0);
        txn(1'b0, 32'h0000_0040, 32'h0, 3'd0, 0, 0, 1);
        chk("rst-mid reread", r_rdata, 32'hDEAD_BEEF);

        // Randomized traffic.
        for (int t = 0; t < 400; t++) begin
            sel = $urandom_range(0, 3);
            a   = $urandom;
            if (sel == 0) a[31:28] = 4'hF;
            else if (a[31:28] == 4'hF) a[31:28] = 4'h0;
            r = $urandom_range(0, 9);
            if (r == 0) ack = 0;
            else if (r == 1) ack = $urandom_range(1, 16);
            else ack = $urandom_range(1, 4);
            txn(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)), ack,
                $urandom, $urandom_range(0, 2));
        end

        mio.cpu_mio = 1'b0;
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
